// File: rtl/line_compose_ctrl.sv
// Scanline composition sequencer: clears the line buffer, walks the layer
// descriptor table and drives tile fetch plus read-modify-write through the combiner.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for line_start
// CLEAR     | zero one line-buffer word per cycle
// DESC      | descriptor read strobe for layer L
// DESC_WAIT | latch descriptor fields, skip layer if disabled
// FETCH     | tile word request held until ack
// RD_HI     | read line-buffer word 2t
// WR_HI     | write combined upper-half result to word 2t
// RD_LO     | read line-buffer word 2t+1
// WR_LO     | write combined lower-half result, advance tile or layer
// DONE      | one-cycle line_done pulse
module line_compose_ctrl #(
    parameter int LINE_WORDS = 160,
    parameter int NUM_LAYERS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    output logic        busy,
    output logic        line_done,
    output logic        desc_rd,
    output logic [3:0]  desc_addr,
    input  logic [23:0] desc_data,
    output logic        tile_req,
    output logic [13:0] tile_addr,
    input  logic        tile_ack,
    input  logic [31:0] tile_data,
    output logic [7:0]  lb_addr,
    output logic        lb_rd,
    output logic        lb_wr,
    output logic [47:0] lb_wdata,
    input  logic [47:0] cmb_result,
    output logic        cmb_first,
    output logic [1:0]  cmb_offset,
    output logic [1:0]  cmb_z,
    output logic [4:0]  cmb_palette,
    output logic [31:0] cmb_tile,
    output logic [11:0] cmb_previous
);

    typedef enum logic [3:0] {
        IDLE, CLEAR, DESC, DESC_WAIT, FETCH, RD_HI, WR_HI, RD_LO, WR_LO, DONE
    } state_t;

    localparam logic [7:0] LAST_WORD  = 8'(LINE_WORDS - 1);
    localparam logic [6:0] LAST_TILE  = 7'(LINE_WORDS / 2 - 1);
    localparam logic [3:0] LAST_LAYER = 4'(NUM_LAYERS - 1);

    state_t      state_q, state_d;
    logic [7:0]  w_q, w_d;
    logic [6:0]  t_q, t_d;
    logic [3:0]  layer_q, layer_d;
    logic [1:0]  z_q, z_d;
    logic [4:0]  pal_q, pal_d;
    logic [1:0]  off_q, off_d;
    logic [13:0] base_q, base_d;
    logic [31:0] tile_q, tile_d;
    logic [11:0] prev_q, prev_d;

    logic        busy_q, busy_d;
    logic        line_done_q, line_done_d;
    logic        desc_rd_q, desc_rd_d;
    logic [3:0]  desc_addr_q, desc_addr_d;
    logic        tile_req_q, tile_req_d;
    logic [13:0] tile_addr_q, tile_addr_d;
    logic [7:0]  lb_addr_q, lb_addr_d;
    logic        lb_rd_q, lb_rd_d;
    logic        lb_wr_q, lb_wr_d;
    logic        cmb_first_q, cmb_first_d;
    logic        wsel_q, wsel_d;
    logic        advance;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        t_d     = t_q;
        layer_d = layer_q;
        z_d     = z_q;
        pal_d   = pal_q;
        off_d   = off_q;
        base_d  = base_q;
        tile_d  = tile_q;
        prev_d  = prev_q;
        advance = 1'b0;

        case (state_q)
            IDLE: begin
                if (line_start) begin
                    state_d = CLEAR;
                    w_d     = '0;
                end
            end
            CLEAR: begin
                if (w_q == LAST_WORD) begin
                    state_d = DESC;
                    layer_d = '0;
                end else begin
                    w_d = w_q + 8'd1;
                end
            end
            DESC: state_d = DESC_WAIT;
            DESC_WAIT: begin
                z_d    = desc_data[22:21];
                pal_d  = desc_data[20:16];
                off_d  = desc_data[15:14];
                base_d = desc_data[13:0];
                prev_d = '0;
                t_d    = '0;
                if (desc_data[23]) state_d = FETCH;
                else               advance = 1'b1;
            end
            FETCH: begin
                if (tile_ack) begin
                    tile_d  = tile_data;
                    state_d = RD_HI;
                end
            end
            RD_HI: state_d = WR_HI;
            WR_HI: state_d = RD_LO;
            RD_LO: state_d = WR_LO;
            WR_LO: begin
                prev_d = tile_q[31:20];
                if (t_q == LAST_TILE) begin
                    advance = 1'b1;
                end else begin
                    t_d     = t_q + 7'd1;
                    state_d = FETCH;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (layer_q == LAST_LAYER) begin
                state_d = DONE;
            end else begin
                layer_d = layer_q + 4'd1;
                state_d = DESC;
            end
        end

        // Outputs are derived from the next state so they register in step with it.
        busy_d      = (state_d != IDLE);
        line_done_d = (state_d == DONE);
        desc_rd_d   = (state_d == DESC);
        desc_addr_d = (state_d == DESC) ? layer_d : desc_addr_q;
        tile_req_d  = (state_d == FETCH);
        tile_addr_d = (state_d == FETCH) ? 14'(base_d + 14'(t_d)) : tile_addr_q;
        lb_rd_d     = (state_d == RD_HI) || (state_d == RD_LO);
        lb_wr_d     = (state_d == CLEAR) || (state_d == WR_HI) || (state_d == WR_LO);
        cmb_first_d = (state_d == WR_HI);
        wsel_d      = (state_d == WR_HI) || (state_d == WR_LO);

        case (state_d)
            CLEAR:        lb_addr_d = w_d;
            RD_HI, WR_HI: lb_addr_d = {t_d, 1'b0};
            RD_LO, WR_LO: lb_addr_d = {t_d, 1'b1};
            default:      lb_addr_d = lb_addr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            w_q         <= '0;
            t_q         <= '0;
            layer_q     <= '0;
            z_q         <= '0;
            pal_q       <= '0;
            off_q       <= '0;
            base_q      <= '0;
            tile_q      <= '0;
            prev_q      <= '0;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
            desc_rd_q   <= 1'b0;
            desc_addr_q <= '0;
            tile_req_q  <= 1'b0;
            tile_addr_q <= '0;
            lb_addr_q   <= '0;
            lb_rd_q     <= 1'b0;
            lb_wr_q     <= 1'b0;
            cmb_first_q <= 1'b0;
            wsel_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            t_q         <= t_d;
            layer_q     <= layer_d;
            z_q         <= z_d;
            pal_q       <= pal_d;
            off_q       <= off_d;
            base_q      <= base_d;
            tile_q      <= tile_d;
            prev_q      <= prev_d;
            busy_q      <= busy_d;
            line_done_q <= line_done_d;
            desc_rd_q   <= desc_rd_d;
            desc_addr_q <= desc_addr_d;
            tile_req_q  <= tile_req_d;
            tile_addr_q <= tile_addr_d;
            lb_addr_q   <= lb_addr_d;
            lb_rd_q     <= lb_rd_d;
            lb_wr_q     <= lb_wr_d;
            cmb_first_q <= cmb_first_d;
            wsel_q      <= wsel_d;
        end
    end

    assign busy         = busy_q;
    assign line_done    = line_done_q;
    assign desc_rd      = desc_rd_q;
    assign desc_addr    = desc_addr_q;
    assign tile_req     = tile_req_q;
    assign tile_addr    = tile_addr_q;
    assign lb_addr      = lb_addr_q;
    assign lb_rd        = lb_rd_q;
    assign lb_wr        = lb_wr_q;
    // Clear writes carry zero; combine writes pass the combiner result straight through.
    assign lb_wdata     = wsel_q ? cmb_result : '0;
    assign cmb_first    = cmb_first_q;
    assign cmb_offset   = off_q;
    assign cmb_z        = z_q;
    assign cmb_palette  = pal_q;
    assign cmb_tile     = tile_q;
    assign cmb_previous = prev_q;

endmodule

// File: tb/tb_line_compose_ctrl.sv
// Bench for line_compose_ctrl: memory, descriptor table and combiner models with
// scoreboards for line-buffer writes, tile addresses and descriptor reads.
module tb_line_compose_ctrl;
    localparam int LW = 8;
    localparam int NL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic        busy, line_done, desc_rd, tile_req, tile_ack, lb_rd, lb_wr, cmb_first;
    logic [3:0]  desc_addr;
    logic [23:0] desc_data = '0;
    logic [13:0] tile_addr;
    logic [31:0] tile_data, cmb_tile;
    logic [7:0]  lb_addr;
    logic [47:0] lb_wdata, cmb_result;
    logic [1:0]  cmb_offset, cmb_z;
    logic [4:0]  cmb_palette;
    logic [11:0] cmb_previous;

    line_compose_ctrl #(.LINE_WORDS(LW), .NUM_LAYERS(NL)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .busy(busy),
        .line_done(line_done), .desc_rd(desc_rd), .desc_addr(desc_addr),
        .desc_data(desc_data), .tile_req(tile_req), .tile_addr(tile_addr),
        .tile_ack(tile_ack), .tile_data(tile_data), .lb_addr(lb_addr),
        .lb_rd(lb_rd), .lb_wr(lb_wr), .lb_wdata(lb_wdata), .cmb_result(cmb_result),
        .cmb_first(cmb_first), .cmb_offset(cmb_offset), .cmb_z(cmb_z),
        .cmb_palette(cmb_palette), .cmb_tile(cmb_tile), .cmb_previous(cmb_previous)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [47:0] data;
        logic        first;
        logic [11:0] prev;
        logic        is_clear;
    } wr_t;

    wr_t         wr_q[$];
    logic [13:0] ta_q[$];
    logic [3:0]  da_q[$];

    logic [23:0] desc_tab [NL];
    logic [47:0] lb_mem [LW];
    logic [47:0] exp_lb [LW];
    logic [47:0] rdata_q = '0;
    int          lat = 0;
    int          req_cnt = 0;
    bit          use_const = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          cur_len = 0;
    int          last_len = 0;
    bit          overlap_err = 1'b0;
    bit          proto_err = 1'b0;
    bit          prev_ack = 1'b0;
    bit          prev_req_wait = 1'b0;
    logic [13:0] prev_taddr = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] tdata(input logic [13:0] a, input bit c);
        if (c) return 32'h8765_4321;
        return {a, 2'b01, a[7:0] ^ 8'h5A, 8'hC3};
    endfunction

    // Stand-in combiner: any deterministic mix that depends on every control input.
    function automatic logic [47:0] combine(input logic [47:0] old, input logic first,
                                            input logic [1:0] off, input logic [1:0] z,
                                            input logic [4:0] pal, input logic [31:0] tile,
                                            input logic [11:0] prev);
        return (old ^ {tile, prev, pal[3:0]}) + {38'd0, pal[4], first, off, z, 4'd0};
    endfunction

    assign cmb_result = combine(rdata_q, cmb_first, cmb_offset, cmb_z, cmb_palette,
                                cmb_tile, cmb_previous);
    assign tile_data  = tdata(tile_addr, use_const);
    assign tile_ack   = tile_req && (req_cnt >= lat);

    always @(posedge clk) begin
        if (desc_rd) desc_data <= desc_tab[desc_addr[1:0]];
        if (lb_rd) rdata_q <= lb_mem[lb_addr[2:0]];
        if (lb_wr) lb_mem[lb_addr[2:0]] = lb_wdata;
        req_cnt <= (tile_req && !tile_ack) ? req_cnt + 1 : 0;
    end

    always @(negedge clk) begin
        wr_t e;
        if (line_done) done_cnt++;
        if (lb_rd && lb_wr) overlap_err = 1'b1;
        if (tile_req && lb_rd) proto_err = 1'b1;
        if (prev_ack && !lb_rd && !reset) proto_err = 1'b1;
        if (tile_req && prev_req_wait && tile_addr != prev_taddr) proto_err = 1'b1;
        if (desc_rd) begin
            if (da_q.size() == 0) check("desc_extra", 1, 0);
            else check("desc_addr", 64'(desc_addr), 64'(da_q.pop_front()));
        end
        if (tile_req && tile_ack) begin
            if (ta_q.size() == 0) check("tile_extra", 1, 0);
            else check("tile_addr", 64'(tile_addr), 64'(ta_q.pop_front()));
            last_len = cur_len + 1;
            cur_len = 0;
        end else if (tile_req) begin
            cur_len++;
        end else begin
            cur_len = 0;
        end
        if (lb_wr) begin
            if (wr_q.size() == 0) begin
                check("wr_extra", 1, 0);
            end else begin
                e = wr_q.pop_front();
                check("wr_addr", 64'(lb_addr), 64'(e.addr));
                check("wr_data", 64'(lb_wdata), 64'(e.data));
                check("wr_first", 64'(cmb_first), 64'(e.first));
                if (!e.is_clear) check("wr_prev", 64'(cmb_previous), 64'(e.prev));
            end
        end
        prev_ack      = tile_req && tile_ack;
        prev_req_wait = tile_req && !tile_ack;
        prev_taddr    = tile_addr;
    end

    task automatic build_expect();
        logic [23:0] d;
        logic [13:0] a;
        logic [31:0] td, tp;
        logic [11:0] prv;
        logic [47:0] nv;
        wr_q.delete();
        ta_q.delete();
        da_q.delete();
        for (int w = 0; w < LW; w++) begin
            exp_lb[w] = '0;
            wr_q.push_back('{8'(w), 48'd0, 1'b0, 12'd0, 1'b1});
        end
        for (int l = 0; l < NL; l++) begin
            da_q.push_back(4'(l));
            d = desc_tab[l];
            if (d[23]) begin
                for (int t = 0; t < LW / 2; t++) begin
                    a = 14'(d[13:0] + 14'(t));
                    ta_q.push_back(a);
                    td = tdata(a, use_const);
                    tp = tdata(14'(a - 14'd1), use_const);
                    prv = (t == 0) ? 12'd0 : tp[31:20];
                    nv = combine(exp_lb[2*t], 1'b1, d[15:14], d[22:21], d[20:16], td, prv);
                    exp_lb[2*t] = nv;
                    wr_q.push_back('{8'(2*t), nv, 1'b1, prv, 1'b0});
                    nv = combine(exp_lb[2*t+1], 1'b0, d[15:14], d[22:21], d[20:16], td, prv);
                    exp_lb[2*t+1] = nv;
                    wr_q.push_back('{8'(2*t+1), nv, 1'b0, prv, 1'b0});
                end
            end
        end
    endtask

    task automatic run_line(input int exp_edges, input int pulse_at, input string tag);
        int n;
        int d0;
        build_expect();
        for (int i = 0; i < LW; i++) lb_mem[i] = {16'hBAD0 | 16'(i), 32'hCAFE_F00D};
        d0 = done_cnt;
        @(negedge clk);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 1);
        n = 0;
        while (!line_done && n < 3000) begin
            @(negedge clk);
            n++;
            line_start = (n == pulse_at);
        end
        line_start = 1'b0;
        check({tag, "_cycles"}, 64'(n), 64'(exp_edges));
        repeat (5) @(negedge clk);
        check({tag, "_idle_busy"}, 64'(busy), 0);
        check({tag, "_done_cnt"}, 64'(done_cnt - d0), 1);
        check({tag, "_wr_left"}, 64'(wr_q.size()), 0);
        check({tag, "_tile_left"}, 64'(ta_q.size()), 0);
        check({tag, "_desc_left"}, 64'(da_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        for (int i = 0; i < NL; i++) desc_tab[i] = '0;
        for (int i = 0; i < LW; i++) lb_mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_strobes", 64'({busy, line_done, desc_rd, tile_req, lb_rd, lb_wr}), 0);
        check("rst_addr", 64'({lb_addr, tile_addr, desc_addr}), 0);
        check("rst_cmb", 64'({cmb_first, cmb_offset, cmb_z, cmb_palette, cmb_tile, cmb_previous}), 0);
        check("rst_wdata", 64'(lb_wdata), 0);

        // All layers disabled: 8 clears + 4 x 2 descriptor cycles, DONE 16 edges after acceptance.
        run_line(LW + 2 * NL, -1, "dis");

        // Reset held 3 cycles while a slow fetch is outstanding.
        desc_tab[0] = {1'b1, 2'd2, 5'd7, 2'd1, 14'h0200};
        lat = 50;
        build_expect();
        d0 = done_cnt;
        @(negedge clk);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        n = 0;
        while (!tile_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_fetch", 64'(tile_req), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_strobes", 64'({busy, line_done, desc_rd, tile_req, lb_rd, lb_wr}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wr_q.delete();
        ta_q.delete();
        da_q.delete();
        repeat (3) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt - d0), 0);
        check("midrst_idle", 64'({busy, tile_req}), 0);

        // Layer 0 only, constant tile data, zero-wait memory.
        for (int i = 0; i < NL; i++) desc_tab[i] = '0;
        desc_tab[0] = {1'b1, 2'd1, 5'd3, 2'd0, 14'h0100};
        use_const = 1'b1;
        lat = 0;
        run_line(LW + 2 * NL + (LW / 2) * 5, -1, "l0");

        // Layer 1 wrapping past the top of memory, 5-cycle ack latency, stray line_start.
        for (int i = 0; i < NL; i++) desc_tab[i] = '0;
        desc_tab[1] = {1'b1, 2'd3, 5'h15, 2'd2, 14'h3FFE};
        use_const = 1'b0;
        lat = 5;
        run_line(LW + 2 * NL + (LW / 2) * 10, 10, "wrap");
        check("wrap_req_len", 64'(last_len), 6);

        // Two enabled layers stacking onto the same words, disabled layers with junk fields.
        desc_tab[0] = {1'b1, 2'd2, 5'h0A, 2'd1, 14'h0020};
        desc_tab[1] = {1'b0, 2'd3, 5'h1F, 2'd3, 14'h3ABC};
        desc_tab[2] = {1'b1, 2'd0, 5'h1F, 2'd3, 14'h0021};
        desc_tab[3] = {1'b0, 2'd1, 5'h11, 2'd2, 14'h1234};
        lat = 0;
        run_line(LW + 2 * NL + 2 * (LW / 2) * 5, -1, "two");

        check("rd_wr_overlap", 64'(overlap_err), 0);
        check("fetch_protocol", 64'(proto_err), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/line_compose_ctrl.md
# line_compose_ctrl

Scanline composition sequencer for the GPU back-buffer path. On each line start it clears the current-line back buffer. It then walks a small layer descriptor table and, for each enabled layer, fetches that layer's 4bpp tile words from video memory. Each tile word is fed twice (upper half, then lower half) through the pixel-combine datapath, with a read-modify-write of the line buffer. The combine datapath itself is external; this block sequences it, drives its control inputs and owns the line-buffer and memory handshakes.

## Interface
- `LINE_WORDS`, 160: line-buffer words per line (4 pixels each); must be even.
- `NUM_LAYERS`, 4: descriptor table entries walked per line (1..16).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `line_start`  in  1  one-cycle request to compose a line; honoured only in IDLE.
- `busy`  out  1  high from the cycle after acceptance through the DONE cycle.
- `line_done`  out  1  one-cycle pulse in DONE.
- `desc_rd`  out  1  descriptor table read strobe.
- `desc_addr`  out  4  layer index.
- `desc_data`  in  24  valid the cycle after `desc_rd`. Fields: [23] enable, [22:21] z, [20:16] palette, [15:14] fine offset, [13:0] tile base word address.
- `tile_req`  out  1  memory read request; held until ack.
- `tile_addr`  out  14  tile word address.
- `tile_ack`  in  1  `tile_data` valid this cycle.
- `tile_data`  in  32  eight 4-bit pixels.
- `lb_addr`  out  8  line-buffer word address.
- `lb_rd`  out  1  line-buffer read; data appears on the combiner input the next cycle.
- `lb_wr`  out  1  line-buffer write.
- `lb_wdata`  out  48  write word {z[7:0], updated[3:0], data[35:0]}.
- `cmb_result`  in  48  combiner output, same packing as `lb_wdata`.
- `cmb_first`, `cmb_offset`[1:0], `cmb_z`[1:0], `cmb_palette`[4:0], `cmb_tile`[31:0], `cmb_previous`[11:0]  out: combiner controls.

## Operation
- States: IDLE, CLEAR, DESC, DESC_WAIT, FETCH, RD_HI, WR_HI, RD_LO, WR_LO, DONE.
- IDLE + `line_start`: go to CLEAR, word counter w=0.
- CLEAR: `lb_wr`=1, `lb_addr`=w, `lb_wdata`=0, one word per cycle.
  - At w=LINE_WORDS-1, go to DESC with layer L=0.
  - Zeroing the updated bits lets the first opaque or transparent layer write unconditionally.
- DESC: `desc_rd`=1, `desc_addr`=L.
- DESC_WAIT: latch z, palette, offset and base from `desc_data`. Clear the previous register to 0 and set tile index t=0.
  - If enable=0: L+1, then go to DESC, or to DONE if L=NUM_LAYERS-1.
- FETCH: `tile_req`=1, `tile_addr`=(base+t) mod 2^14. On `tile_ack`, latch `tile_data` into the tile register and go to RD_HI.
- RD_HI: `lb_rd`=1, `lb_addr`=2t.
- WR_HI: `lb_wr`=1, `lb_addr`=2t, `cmb_first`=1, `lb_wdata`=`cmb_result`.
- RD_LO: `lb_rd`=1, `lb_addr`=2t+1.
- WR_LO: write as in WR_HI with `cmb_first`=0. Previous register <= tile register[31:20].
  - If t=LINE_WORDS/2-1, advance the layer as above. Otherwise t+1 and go to FETCH.
- DONE: `line_done`=1, then IDLE.
- `cmb_tile`, `cmb_z`, `cmb_palette`, `cmb_offset` and `cmb_previous` are registered and held stable throughout each RD/WR pair. `cmb_offset` equals the descriptor fine offset.
- `line_start` outside IDLE is ignored and not queued.
- Layer order is fixed 0..NUM_LAYERS-1. Depth priority is resolved in the combiner by z, not by order.

## Timing
- Reset values: state=IDLE; `busy`, `line_done`, `desc_rd`, `tile_req`, `lb_rd`, `lb_wr`=0; all address, data and cmb outputs 0; counters and previous register 0.
- Reset asserted mid-line: IDLE on the next edge with every strobe low. The line is abandoned, with no `line_done`, and any outstanding `tile_req` is dropped.
- CLEAR takes LINE_WORDS cycles. A disabled layer costs 2 cycles.
- Per tile word: 1+k cycles in FETCH (k = ack latency, k≥0 cycles before ack) plus 4 cycles RD/WR.
- Total for E enabled layers at zero-wait memory: 1 + LINE_WORDS + 2·NUM_LAYERS + E·(LINE_WORDS/2)·5 + 1 cycles, from acceptance to the `line_done` pulse.
- `tile_addr` stays stable while `tile_req` is high. `tile_ack` while `tile_req`=0 is ignored.
- `lb_rd` and `lb_wr` are never high in the same cycle.

## Test plan
- Reset held 3 cycles mid-FETCH -> all strobes 0 the next cycle, `busy`=0, no `line_done`; a later `line_start` composes normally.
- LINE_WORDS=8, all layers disabled, `line_start` -> 8 zero writes at addresses 0..7, then 4 `desc_rd` at addresses 0..3, `line_done` on cycle 1+8+8+1=18.
- Layer 0 {enable, z=1, pal=3, off=0, base=0x100}, zero-wait memory, tile_data=0x87654321 -> `tile_addr` 0x100..0x103. Word 0 written with `cmb_first`=1, word 1 with `cmb_first`=0. `cmb_previous` is 0 for tile 0 and 0x876 for tile 1.
- `tile_ack` delayed 5 cycles -> `tile_req` and `tile_addr` held stable for 6 cycles; no `lb_rd` until the cycle after ack.
- base=0x3FFE -> `tile_addr` sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- `line_start` pulsed while `busy` -> ignored; exactly one `line_done` is produced.
